// File: rtl/fft_input_loader.sv
// Streams one 2^N_LOG2-point complex frame into FFT bank 0 in bit-reversed order,
// then launches the address generator and holds off input until the FFT core finishes.
module fft_input_loader #(
  parameter int N_LOG2 = 10,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DATA_W-1:0] sample_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic                fft_done_i,
  output logic                wr_en_o,
  output logic [N_LOG2-1:0]   wr_addr_o,
  output logic [2*DATA_W-1:0] wr_data_o,
  output logic                start_o,
  output logic                busy_o,
  output logic                overrun_o
);

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] BUSY   = 2'd2;

  localparam logic [N_LOG2-1:0] CNT_LAST = '1;

  function automatic logic [N_LOG2-1:0] bit_rev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    r = '0;
    for (int k = 0; k < N_LOG2; k++) begin
      r[N_LOG2-1-k] = v[k];
    end
    return r;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [N_LOG2-1:0]   cnt_q, cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [N_LOG2-1:0]   wr_addr_q, wr_addr_d;
  logic [2*DATA_W-1:0] wr_data_q, wr_data_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                accept;

  // ready is gated by rst so nothing is taken while reset is held
  assign ready_o = (state_q == FILL) && !rst;
  assign accept  = valid_i && ready_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = accept;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    start_d   = (state_q == LAUNCH);
    busy_d    = (state_q == BUSY) && !fft_done_i;
    overrun_d = overrun_q || (valid_i && !ready_o);

    if (accept) begin
      wr_addr_d = bit_rev(cnt_q);
      wr_data_d = sample_i;
      cnt_d     = cnt_q + 1'b1;
    end

    // start_o is registered off LAUNCH so it lands one cycle after the last write
    case (state_q)
      FILL:    if (accept && (cnt_q == CNT_LAST)) state_d = LAUNCH;
      LAUNCH:  state_d = BUSY;
      BUSY:    if (fft_done_i) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign start_o   = start_q;
  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Randomized bench for fft_input_loader, checked against a frame-level reference model.
module tb_fft_input_loader;

  localparam int N_LOG2 = 10;
  localparam int DATA_W = 16;
  localparam int FRAME  = 1 << N_LOG2;

  logic                clk;
  logic                rst;
  logic [2*DATA_W-1:0] sample_i;
  logic                valid_i;
  logic                ready_o;
  logic                fft_done_i;
  logic                wr_en_o;
  logic [N_LOG2-1:0]   wr_addr_o;
  logic [2*DATA_W-1:0] wr_data_o;
  logic                start_o;
  logic                busy_o;
  logic                overrun_o;

  fft_input_loader #(.N_LOG2(N_LOG2), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_i   (sample_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .fft_done_i (fft_done_i),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .start_o    (start_o),
    .busy_o     (busy_o),
    .overrun_o  (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: samples taken in the current frame, and cycles since the
  // frame's last sample was taken (-1 while collecting).
  int                  m_n;
  int                  m_post;
  logic                m_wr;
  logic [N_LOG2-1:0]   m_addr;
  logic [2*DATA_W-1:0] m_data;
  logic                m_ovr;
  logic                last_acc;

  int                  wr_cnt;
  int                  st_cnt;
  logic [N_LOG2-1:0]   obs_addr [FRAME];
  logic [2*DATA_W-1:0] obs_data [FRAME];

  function automatic int rev(input int x);
    int r = 0;
    int v = x;
    for (int k = 0; k < N_LOG2; k++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_n = 0; m_post = -1; m_wr = 1'b0; m_addr = '0; m_data = '0; m_ovr = 1'b0;
  endtask

  task automatic cycle();
    bit rdy;
    rdy = (m_post < 0);
    last_acc = valid_i && rdy;
    @(posedge clk);
    m_wr = last_acc;
    if (valid_i && !rdy) m_ovr = 1'b1;
    if (m_post >= 0) begin
      if (m_post >= 2 && fft_done_i) m_post = -1;
      else m_post++;
    end else if (last_acc) begin
      m_addr = N_LOG2'(rev(m_n));
      m_data = sample_i;
      m_n++;
      if (m_n == FRAME) begin
        m_n = 0;
        m_post = 1;
      end
    end
    #1;
    chk("wr_en",   64'(wr_en_o),   64'(m_wr));
    chk("wr_addr", 64'(wr_addr_o), 64'(m_addr));
    chk("wr_data", 64'(wr_data_o), 64'(m_data));
    chk("start",   64'(start_o),   64'(m_post == 2));
    chk("busy",    64'(busy_o),    64'(m_post >= 3));
    chk("ready",   64'(ready_o),   64'(m_post < 0));
    chk("overrun", 64'(overrun_o), 64'(m_ovr));
    if (wr_en_o && wr_cnt < FRAME) begin
      obs_addr[wr_cnt] = wr_addr_o;
      obs_data[wr_cnt] = wr_data_o;
    end
    if (wr_en_o) wr_cnt++;
    if (start_o) st_cnt++;
  endtask

  task automatic run_accepts(input int target, input bit gaps, input bit seq);
    int got = 0;
    int budget = 0;
    while (got < target && budget < 20000) begin
      valid_i  = gaps ? 1'($urandom % 2) : 1'b1;
      sample_i = seq ? ((got == 2) ? 32'h80017FFF : 32'(got)) : 32'($urandom);
      cycle();
      if (last_acc) got++;
      budget++;
    end
    valid_i = 1'b0;
    chk("accept_budget", 64'(got), 64'(target));
  endtask

  task automatic wait_busy();
    int b = 0;
    while (!busy_o && b < 10) begin
      cycle();
      b++;
    end
    chk("busy_seen", 64'(busy_o), 64'd1);
  endtask

  task automatic pulse_done();
    fft_done_i = 1'b1;
    cycle();
    fft_done_i = 1'b0;
    cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"},   64'(wr_en_o),   64'd0);
    chk({tag, "_wr_addr"}, 64'(wr_addr_o), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data_o), 64'd0);
    chk({tag, "_start"},   64'(start_o),   64'd0);
    chk({tag, "_busy"},    64'(busy_o),    64'd0);
    chk({tag, "_overrun"}, 64'(overrun_o), 64'd0);
    chk({tag, "_ready"},   64'(ready_o),   64'd0);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; sample_i = '0; fft_done_i = 1'b0;
    model_reset();
    wr_cnt = 0; st_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    #1;
    chk("ready_after_rel", 64'(ready_o), 64'd1);

    // Frame A: back-to-back, data = index, special word at index 2
    wr_cnt = 0; st_cnt = 0;
    run_accepts(FRAME, 1'b0, 1'b1);
    wait_busy();
    chk("A_wr_count",  64'(wr_cnt), 64'(FRAME));
    chk("A_start_cnt", 64'(st_cnt), 64'd1);
    chk("A_addr0",    64'(obs_addr[0]),    64'd0);
    chk("A_addr1",    64'(obs_addr[1]),    64'd512);
    chk("A_addr3",    64'(obs_addr[3]),    64'd768);
    chk("A_addr1023", 64'(obs_addr[1023]), 64'd1023);
    chk("A_addr2",    64'(obs_addr[2]),    64'd256);
    chk("A_data2",    64'(obs_data[2]),    64'h80017FFF);
    chk("A_data5",    64'(obs_data[5]),    64'd5);

    // Push while busy: rejected, overrun becomes sticky
    valid_i = 1'b1;
    repeat (5) cycle();
    valid_i = 1'b0;
    chk("ovr_set", 64'(overrun_o), 64'd1);
    pulse_done();
    chk("ovr_sticky", 64'(overrun_o), 64'd1);
    // Done while collecting has no effect
    pulse_done();
    chk("done_in_fill_ready", 64'(ready_o), 64'd1);

    // Frame B: random 50% gaps
    wr_cnt = 0; st_cnt = 0;
    run_accepts(FRAME, 1'b1, 1'b0);
    wait_busy();
    chk("B_wr_count",  64'(wr_cnt), 64'(FRAME));
    chk("B_start_cnt", 64'(st_cnt), 64'd1);
    chk("B_addr0",     64'(obs_addr[0]), 64'd0);
    chk("B_addr1",     64'(obs_addr[1]), 64'd512);
    pulse_done();

    // Reset in the middle of a frame
    wr_cnt = 0; st_cnt = 0;
    run_accepts(300, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("mid_hold");
    rst = 1'b0;
    #1;
    chk("mid_ready_rel", 64'(ready_o), 64'd1);
    chk("mid_no_start", 64'(st_cnt), 64'd0);

    // Frame C after the aborted one
    wr_cnt = 0; st_cnt = 0;
    run_accepts(FRAME, 1'b1, 1'b0);
    wait_busy();
    chk("C_wr_count",  64'(wr_cnt), 64'(FRAME));
    chk("C_start_cnt", 64'(st_cnt), 64'd1);
    chk("C_addr0",     64'(obs_addr[0]), 64'd0);
    pulse_done();
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
